cfg_scan_loader: RTL and testbench

Bitstream loader that sits directly upstream of the fabric configuration scan chain (connection blocks, switch blocks, CLBs daisy-chained through their `shift_reg` instances). It accepts configuration words over a valid/ready handshake, serializes them LSB-first onto the chain's `scan_in`, and gates `scan_en` so exactly `CHAIN_LENGTH` bits are shifted per load. A two-entry buffer (holding register plus shifter) allows continuous one-bit-per-cycle shifting when the source keeps up.

---
 rtl/fpga_cfg_pkg.sv | 25 ++
 rtl/cfg_word_shifter.sv | 93 +++++++++
 rtl/cfg_scan_loader.sv | 122 ++++++++++++
 tb/tb_cfg_scan_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-fabric definitions: loader state encoding, the default
// configuration word width and the fabric's total scan-chain length.
package fpga_cfg_pkg;

  // Loader FSM states; the encoding is visible on the loader's state_dbg port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } cfg_state_e;

  // Width of one configuration word on the loader's input stream.
  localparam int CFG_WORD_WIDTH = 8;

  // Per-tile configuration bits contributed by each chained element.
  localparam int FABRIC_TILES  = 4;
  localparam int CLB_CFG_BITS  = 10;
  localparam int CB_CFG_BITS   = 2;
  localparam int SB_CFG_BITS   = 4;

  // Total scan-chain length; also consumed by the fabric top.
  localparam int FABRIC_CHAIN_LENGTH =
    FABRIC_TILES * (CLB_CFG_BITS + CB_CFG_BITS + SB_CFG_BITS);

endpackage

// File: rtl/cfg_word_shifter.sv
// Two-entry word buffer feeding the scan chain: a holding register in front
// of a right-shifting serializer. A word carries its own count of valid bits
// so a truncated last word simply runs out early and its upper bits are never
// presented. The shifter advances every cycle it holds a valid bit.
module cfg_word_shifter
  import fpga_cfg_pkg::*;
#(
  parameter int  WORD_WIDTH = CFG_WORD_WIDTH,
  localparam int BW         = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic [BW-1:0]         load_bits,
  output logic                  shift_bit,
  output logic                  shift_valid,
  output logic                  hold_full_nxt
);

  logic [WORD_WIDTH-1:0] sh_data_q, sh_data_d;
  logic [BW-1:0]         sh_cnt_q, sh_cnt_d;
  logic [WORD_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [BW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                  hold_full_q, hold_full_d;
  logic                  sh_valid_q;
  logic                  sh_free;

  // The shifter can take a new word when empty or on its final valid bit.
  assign sh_free = (sh_cnt_q == '0) || (sh_cnt_q == BW'(1));

  // Next-state of buffer: shift, then refill from holding register or input.
  always_comb begin
    sh_data_d   = sh_data_q;
    sh_cnt_d    = sh_cnt_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    hold_full_d = hold_full_q;
    if (clear) begin
      sh_data_d   = '0;
      sh_cnt_d    = '0;
      hold_data_d = '0;
      hold_cnt_d  = '0;
      hold_full_d = 1'b0;
    end else begin
      if (sh_cnt_q != '0) begin
        sh_data_d = sh_data_q >> 1;
        sh_cnt_d  = sh_cnt_q - BW'(1);
      end
      if (sh_free) begin
        // A buffered word always has priority; the loader never offers a new
        // word while the holding register is occupied.
        if (hold_full_q) begin
          sh_data_d   = hold_data_q;
          sh_cnt_d    = hold_cnt_q;
          hold_full_d = 1'b0;
        end else if (load) begin
          sh_data_d = load_data;
          sh_cnt_d  = load_bits;
        end
      end else if (load) begin
        hold_data_d = load_data;
        hold_cnt_d  = load_bits;
        hold_full_d = 1'b1;
      end
    end
  end

  // Buffer registers; shift_valid is its own flop so the enable is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data_q   <= '0;
      sh_cnt_q    <= '0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      sh_valid_q  <= 1'b0;
    end else begin
      sh_data_q   <= sh_data_d;
      sh_cnt_q    <= sh_cnt_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_full_q <= hold_full_d;
      sh_valid_q  <= (sh_cnt_d != '0);
    end
  end

  assign shift_bit     = sh_data_q[0];
  assign shift_valid   = sh_valid_q;
  assign hold_full_nxt = hold_full_d;

endmodule

// File: rtl/cfg_scan_loader.sv
// Configuration bitstream loader in front of the fabric scan chain. Words are
// serialized LSB-first; exactly CHAIN_LENGTH enables are issued per load, so
// the first bit shifted lands in the chain element farthest from the loader.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready are
// both high. in_ready is a registered output that never depends on in_valid;
// the source may hold in_valid/in_data indefinitely and must keep them stable
// until the transfer edge. Words offered outside a load, or beyond the last
// needed bit, are simply left unaccepted.
module cfg_scan_loader
  import fpga_cfg_pkg::*;
#(
  parameter int  WORD_WIDTH   = CFG_WORD_WIDTH,
  parameter int  CHAIN_LENGTH = FABRIC_CHAIN_LENGTH,
  localparam int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  scan_clk,
  input  logic                  scan_rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  chain_scan_in,
  output logic                  chain_scan_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  bits_left,
  output cfg_state_e            state_dbg
);

  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int AW = (CNT_WIDTH > BW) ? CNT_WIDTH : BW;
  localparam logic [CNT_WIDTH-1:0] CHAIN_CNT = CNT_WIDTH'(CHAIN_LENGTH);

  cfg_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] bits_left_q, bits_left_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 start_take;
  logic                 accept;
  logic                 shift_bit;
  logic                 shift_valid;
  logic                 hold_full_nxt;
  logic [AW-1:0]        rem_w;
  logic [BW-1:0]        word_bits;

  assign start_take = start && (state_q != ST_LOAD);
  assign accept     = in_valid && in_ready_q;

  // FSM state register.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // FSM next state: the load ends on the cycle that presents the final bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (shift_valid && (bits_left_q == CNT_WIDTH'(1))) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: status decoded from state, datapath outputs straight from flops.
  always_comb begin
    busy          = (state_q == ST_LOAD);
    done          = (state_q == ST_DONE);
    in_ready      = in_ready_q;
    chain_scan_en = shift_valid;
    chain_scan_in = shift_bit;
    bits_left     = bits_left_q;
    state_dbg     = state_q;
  end

  // Counters: accepted-bit budget (capped at the chain length) and bits left.
  always_comb begin
    rem_w       = AW'(CHAIN_CNT - acc_q);
    word_bits   = (rem_w >= AW'(WORD_WIDTH)) ? BW'(WORD_WIDTH) : BW'(rem_w);
    acc_d       = acc_q;
    bits_left_d = bits_left_q;
    if (start_take) begin
      acc_d       = '0;
      bits_left_d = CHAIN_CNT;
    end else begin
      if (accept) acc_d = acc_q + CNT_WIDTH'(word_bits);
      if ((state_q == ST_LOAD) && shift_valid) bits_left_d = bits_left_q - CNT_WIDTH'(1);
    end
    // Registered ready: computed from next-cycle state so it is exact.
    in_ready_d = (state_d == ST_LOAD) && !hold_full_nxt && (acc_d < CHAIN_CNT);
  end

  // Counter and ready registers.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      bits_left_q <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      bits_left_q <= bits_left_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
    end
  end

  cfg_word_shifter #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .clk           (scan_clk),
    .rst_n         (scan_rst_n),
    .clear         (start_take),
    .load          (accept),
    .load_data     (in_data),
    .load_bits     (word_bits),
    .shift_bit     (shift_bit),
    .shift_valid   (shift_valid),
    .hold_full_nxt (hold_full_nxt)
  );

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Bench for cfg_scan_loader with an 8-bit word and a 20-bit chain.
module tb_cfg_scan_loader;
  import fpga_cfg_pkg::*;

  localparam int WW = 8;
  localparam int CL = 20;
  localparam int CW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          chain_scan_in;
  logic          chain_scan_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] bits_left;
  cfg_state_e    state_dbg;

  cfg_scan_loader #(
    .WORD_WIDTH   (WW),
    .CHAIN_LENGTH (CL)
  ) dut (
    .scan_clk      (clk),
    .scan_rst_n    (rst_n),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .chain_scan_in (chain_scan_in),
    .chain_scan_en (chain_scan_en),
    .busy          (busy),
    .done          (done),
    .bits_left     (bits_left),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic          exp_q[$];          // expected serial bits, in shift order
  logic [CL-1:0] exp_chain = '0;    // expected chain image, [CL-1] farthest
  logic [CL-1:0] chain_m = '0;      // shift_reg model of the fabric chain
  int            acc_m = 0;         // bits of the current load already queued
  int            en_count = 0;      // enables seen in the current load
  int            gap_count = 0;     // busy cycles without enable after first bit
  logic          mon_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is the concatenation of accepted words, LSB
  // first, truncated to the chain length; bit i ends in chain element CL-1-i.
  task automatic push_word(input logic [WW-1:0] w);
    for (int i = 0; i < WW; i++) begin
      if (acc_m < CL) begin
        exp_q.push_back(w[i]);
        exp_chain[CL-1-acc_m] = w[i];
        acc_m++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("bits_left_track", 32'(bits_left), 32'(CL - en_count));
      if (chain_scan_en) begin
        if (exp_q.size() == 0) begin
          check("extra_scan_en", 32'(chain_scan_en), 32'(0));
        end else begin
          mon_bit = exp_q.pop_front();
          check("scan_in_bit", 32'(chain_scan_in), 32'(mon_bit));
        end
        chain_m = {chain_m[CL-2:0], chain_scan_in};
        en_count++;
      end else if (busy && en_count > 0) begin
        gap_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    acc_m = 0; en_count = 0; gap_count = 0; exp_chain = '0;
    check("start_busy", 32'(busy), 32'(1));
    check("start_in_ready", 32'(in_ready), 32'(1));
    check("start_bits_left", 32'(bits_left), 32'(CL));
    check("start_done_low", 32'(done), 32'(0));
    check("start_state", 32'(state_dbg), 32'(ST_LOAD));
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    in_data = w;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push_word(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_word_timeout", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_load(input string tag);
    for (int t = 0; t < 300 && !done; t++) @(negedge clk);
    check($sformatf("%s_done", tag), 32'(done), 32'(1));
    check($sformatf("%s_busy", tag), 32'(busy), 32'(0));
    check($sformatf("%s_bits_left", tag), 32'(bits_left), 32'(0));
    check($sformatf("%s_scan_en", tag), 32'(chain_scan_en), 32'(0));
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'(0));
    check($sformatf("%s_en_count", tag), 32'(en_count), 32'(CL));
    check($sformatf("%s_queue_empty", tag), 32'(exp_q.size()), 32'(0));
    check($sformatf("%s_chain", tag), 32'(chain_m), 32'(exp_chain));
    check($sformatf("%s_state", tag), 32'(state_dbg), 32'(ST_DONE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'(0));
    check($sformatf("%s_scan_in", tag), 32'(chain_scan_in), 32'(0));
    check($sformatf("%s_scan_en", tag), 32'(chain_scan_en), 32'(0));
    check($sformatf("%s_busy", tag), 32'(busy), 32'(0));
    check($sformatf("%s_done", tag), 32'(done), 32'(0));
    check($sformatf("%s_bits_left", tag), 32'(bits_left), 32'(0));
    check($sformatf("%s_state", tag), 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Words offered while idle are not taken.
    in_data = 8'h5A; in_valid = 1'b1;
    repeat (3) begin @(negedge clk); check("idle_in_ready", 32'(in_ready), 32'(0)); end
    in_valid = 1'b0;

    // Back-to-back load followed by over-supply of 0xFF.
    do_start();
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF9);
    in_data = 8'hFF; in_valid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (!done) check("oversupply_in_ready", 32'(in_ready), 32'(0));
    end
    finish_load("b2b");
    check("b2b_gap", 32'(gap_count), 32'(0));
    check("b2b_chain_pattern", 32'(chain_m), 32'(20'hA53C9));
    repeat (4) begin @(negedge clk); check("done_in_ready", 32'(in_ready), 32'(0)); end
    check("done_hold_en_count", 32'(en_count), 32'(CL));
    @(posedge clk); #1 in_valid = 1'b0;

    // Source stall of five bit-times after word 1, with a start during LOAD.
    do_start();
    send_word(8'hA5);
    idle_cycles(10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("ignored_start_bits_left", 32'(bits_left), 32'(12));
    check("ignored_start_busy", 32'(busy), 32'(1));
    check("ignored_start_state", 32'(state_dbg), 32'(ST_LOAD));
    idle_cycles(1);
    send_word(8'h3C);
    send_word(8'hF9);
    finish_load("stall");
    check("stall_gap", 32'(gap_count), 32'(5));
    check("stall_chain_pattern", 32'(chain_m), 32'(20'hA53C9));

    // Asynchronous reset at bit 10.
    do_start();
    send_word(8'hA5);
    send_word(8'h3C);
    for (int t = 0; t < 100 && en_count < 10; t++) begin @(negedge clk); #1; end
    check("reached_bit10", 32'(en_count), 32'(10));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midload_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_start();
    send_word(8'($urandom_range(0, 255)));
    send_word(8'($urandom_range(0, 255)));
    send_word(8'($urandom_range(0, 255)));
    finish_load("after_reset");
    check("after_reset_gap", 32'(gap_count), 32'(0));

    // Reload from DONE with all-zero words.
    do_start();
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h00);
    finish_load("zeros");
    check("zeros_chain", 32'(chain_m), 32'(0));

    // Randomized loads with random source stalls.
    for (int l = 0; l < 10; l++) begin
      do_start();
      for (int w = 0; w < 3; w++) begin
        n = $urandom_range(0, 12);
        idle_cycles(n);
        send_word(8'($urandom_range(0, 255)));
      end
      finish_load("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
